// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - funct3 constants, FSM states and decode helpers for dmem_lsu
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC1 = 2'd1,
        ST_ACC2 = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Byte mask of the access size, right-aligned (funct3[2] only selects extension)
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Reserved encodings, and unsigned variants that have no store counterpart
    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        case (funct3)
            3'b011, 3'b110, 3'b111: return 1'b1;
            F3_BU, F3_HU:           return we;
            default:                return 1'b0;
        endcase
    endfunction

    // Access that crosses a word boundary
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b01:   return off == 2'd3;
            2'b10:   return off != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// rtl/dmem_lsu_align.sv - lane shifting for both access halves and load merge/extension
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] load_data
);

    logic [7:0]  be_wide;
    logic [63:0] wdata_wide;
    logic [63:0] merged;

    // Shift into an 8-lane / 64-bit window: the low half feeds ACC1, the spill feeds ACC2
    assign be_wide    = {4'b0000, size_mask(funct3)} << off;
    assign wdata_wide = {32'h0, wdata} << {off, 3'b000};
    assign be_lo      = be_wide[3:0];
    assign be_hi      = be_wide[7:4];
    assign wdata_lo   = wdata_wide[31:0];
    assign wdata_hi   = wdata_wide[63:32];
    assign merged     = {word1, word0} >> {off, 3'b000};

    // Truncate to the access size and extend according to funct3
    always_comb begin
        load_data = merged[31:0];
        case (funct3)
            F3_B:    load_data = {{24{merged[7]}}, merged[7:0]};
            F3_H:    load_data = {{16{merged[15]}}, merged[15:0]};
            F3_BU:   load_data = {24'h0, merged[7:0]};
            F3_HU:   load_data = {16'h0, merged[15:0]};
            default: load_data = merged[31:0];
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32 load/store unit; DMEM_LSU_MISALIGNED_EN enables split misaligned accesses
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_misaligned,
    output logic              rsp_illegal,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

`ifdef DMEM_LSU_MISALIGNED_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    state_t            state;
    state_t            state_next;
    logic              lat_we;
    logic [2:0]        lat_funct3;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [31:0]       word0;
    logic [31:0]       word1;

    logic              illegal;
    logic              misaligned;
    logic              error;
    logic              split;
    logic [ADDR_W-3:0] word_idx;
    logic [ADDR_W-3:0] word_idx_next;
    logic [3:0]        be_lo;
    logic [3:0]        be_hi;
    logic [31:0]       wdata_lo;
    logic [31:0]       wdata_hi;
    logic [31:0]       load_data;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W];

    assign illegal       = is_illegal(lat_we, lat_funct3);
    assign misaligned    = is_misaligned(lat_funct3, lat_addr[1:0]);
    assign error         = illegal | (misaligned & ~SPLIT_EN);
    assign split         = misaligned & ~illegal & SPLIT_EN;
    assign word_idx      = lat_addr[ADDR_W-1:2];
    assign word_idx_next = word_idx + 1'b1;

    dmem_lsu_align u_align (
        .funct3    (lat_funct3),
        .off       (lat_addr[1:0]),
        .wdata     (lat_wdata),
        .word0     (word0),
        .word1     (word1),
        .be_lo     (be_lo),
        .be_hi     (be_hi),
        .wdata_lo  (wdata_lo),
        .wdata_hi  (wdata_hi),
        .load_data (load_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latch on accept and read-word capture in each access cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we     <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_addr   <= '0;
            lat_wdata  <= 32'h0;
            word0      <= 32'h0;
            word1      <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we     <= req_we;
                        lat_funct3 <= req_funct3;
                        lat_addr   <= req_addr[ADDR_W-1:0];
                        lat_wdata  <= req_wdata;
                        word1      <= 32'h0;
                    end
                end
                ST_ACC1: word0 <= mem_rdata;
                ST_ACC2: word1 <= mem_rdata;
                default: ;
            endcase
        end
    end

    // Next state, memory strobes and response; errors walk ACC1 with strobes held off
    always_comb begin
        state_next     = state;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_rdata      = 32'h0;
        rsp_misaligned = 1'b0;
        rsp_illegal    = 1'b0;
        mem_addr       = '0;
        mem_re         = 1'b0;
        mem_we         = 1'b0;
        mem_be         = 4'b0000;
        mem_wdata      = 32'h0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = ST_ACC1;
                end
            end
            ST_ACC1: begin
                mem_addr = word_idx;
                if (!error) begin
                    mem_re    = ~lat_we;
                    mem_we    = lat_we;
                    mem_be    = be_lo;
                    mem_wdata = wdata_lo;
                end
                state_next = split ? ST_ACC2 : ST_RESP;
            end
            ST_ACC2: begin
                mem_addr   = word_idx_next;
                mem_re     = ~lat_we;
                mem_we     = lat_we;
                mem_be     = be_hi;
                mem_wdata  = wdata_hi;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid      = 1'b1;
                rsp_illegal    = illegal;
                rsp_misaligned = misaligned & ~illegal & ~SPLIT_EN;
                rsp_rdata      = (lat_we || error) ? 32'h0 : load_data;
                state_next     = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu; honours DMEM_LSU_MISALIGNED_EN
module tb_dmem_lsu;

`ifdef DMEM_LSU_MISALIGNED_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif
    localparam int ADDR_W    = 6;
    localparam int MEM_BYTES = 64;
    localparam int MEM_WORDS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        rsp_illegal;
    logic [3:0]  mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] tb_mem [MEM_WORDS];
    logic [7:0]  ref_mem [MEM_BYTES];

    int errors = 0;
    int checks = 0;
    int both_strobes = 0;

    // observed per transaction
    int          obs_lat;
    int          obs_nstr;
    logic [3:0]  obs_be1, obs_be2;
    logic [3:0]  obs_addr1, obs_addr2;
    logic [31:0] obs_wd1, obs_wd2;
    logic [31:0] obs_rdata;
    logic        obs_ill, obs_mis;

    // model predictions
    int          m_lat;
    int          m_nstr;
    logic [31:0] m_rdata;
    logic        m_ill, m_mis;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        ill;
        logic        mis;
        logic [3:0]  be;
        logic [3:0]  maddr;
        logic [31:0] mwd;
    } vec_t;

    vec_t tbl[13];

    dmem_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .rsp_illegal    (rsp_illegal),
        .mem_addr       (mem_addr),
        .mem_re         (mem_re),
        .mem_we         (mem_we),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_addr];

    // byte-enabled write memory
    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (mem_re && mem_we) both_strobes++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Byte-level reference: size/offset arithmetic over a flat byte array
    task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd);
        int size, base, off;
        logic [31:0] v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        base = int'(addr[5:0]);
        off  = base % 4;
        m_ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5));
        m_mis = 1'b0;
        m_rdata = 32'h0;
        m_lat = 2;
        m_nstr = 0;
        if (m_ill) return;
        if (off + size > 4) begin
            if (!SPLIT_EN) begin
                m_mis = 1'b1;
                return;
            end
            m_lat = 3;
            m_nstr = 2;
        end else begin
            m_nstr = 1;
        end
        if (we) begin
            for (int i = 0; i < size; i++) ref_mem[(base + i) % MEM_BYTES] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[(base + i) % MEM_BYTES];
            if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFFFF00;
            if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF0000;
            m_rdata = v;
        end
    endtask

    // Issue one request, observe up to 6 cycles, compare against the model
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
        @(negedge clk);
        chk("ready_before_req", {31'h0, req_ready}, 32'd1);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1;
        // garbage while busy must be ignored
        req_valid = 1'b1; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        obs_lat = 0; obs_nstr = 0;
        obs_be1 = 4'h0; obs_be2 = 4'h0; obs_addr1 = 4'h0; obs_addr2 = 4'h0;
        obs_wd1 = 32'h0; obs_wd2 = 32'h0;
        obs_rdata = 32'h0; obs_ill = 1'b0; obs_mis = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_re || mem_we) obs_nstr++;
            if (k == 1) begin obs_be1 = mem_be; obs_addr1 = mem_addr; obs_wd1 = mem_wdata; end
            if (k == 2) begin obs_be2 = mem_be; obs_addr2 = mem_addr; obs_wd2 = mem_wdata; end
            if (rsp_valid) begin
                obs_lat = k; obs_rdata = rsp_rdata; obs_ill = rsp_illegal; obs_mis = rsp_misaligned;
                break;
            end
        end
        req_valid = 1'b0;
        model_req(we, f3, addr, wd);
        chk("latency", obs_lat, m_lat);
        chk("nstrobes", obs_nstr, m_nstr);
        chk("rsp_rdata", obs_rdata, m_rdata);
        chk("rsp_illegal", {31'h0, obs_ill}, {31'h0, m_ill});
        chk("rsp_misaligned", {31'h0, obs_mis}, {31'h0, m_mis});
    endtask

    task automatic check_mem();
        logic [31:0] e;
        for (int w = 0; w < MEM_WORDS; w++) begin
            e = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
            chk($sformatf("mem_word%0d", w), tb_mem[w], e);
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;

        tbl[0]  = '{1'b1, 3'b010, 32'h08, 32'h8899AABB, 32'h0,        1'b0, 1'b0, 4'b1111, 4'd2,  32'h8899AABB};
        tbl[1]  = '{1'b0, 3'b010, 32'h08, 32'h0,        32'h8899AABB, 1'b0, 1'b0, 4'b1111, 4'd2,  32'h0};
        tbl[2]  = '{1'b1, 3'b010, 32'h08, 32'h0080FF00, 32'h0,        1'b0, 1'b0, 4'b1111, 4'd2,  32'h0080FF00};
        tbl[3]  = '{1'b0, 3'b000, 32'h0A, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 4'b0100, 4'd2,  32'h0};
        tbl[4]  = '{1'b0, 3'b100, 32'h0A, 32'h0,        32'h00000080, 1'b0, 1'b0, 4'b0100, 4'd2,  32'h0};
        tbl[5]  = '{1'b1, 3'b001, 32'h06, 32'h00001234, 32'h0,        1'b0, 1'b0, 4'b1100, 4'd1,  32'h12340000};
        tbl[6]  = '{1'b0, 3'b001, 32'h06, 32'h0,        32'h00001234, 1'b0, 1'b0, 4'b1100, 4'd1,  32'h0};
        tbl[7]  = '{1'b0, 3'b101, 32'h08, 32'h0,        32'h0000FF00, 1'b0, 1'b0, 4'b0011, 4'd2,  32'h0};
        tbl[8]  = '{1'b0, 3'b001, 32'h08, 32'h0,        32'hFFFFFF00, 1'b0, 1'b0, 4'b0011, 4'd2,  32'h0};
        tbl[9]  = '{1'b0, 3'b011, 32'h00, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 4'd0,  32'h0};
        tbl[10] = '{1'b1, 3'b100, 32'h04, 32'h55,       32'h0,        1'b1, 1'b0, 4'b0000, 4'd0,  32'h0};
        tbl[11] = '{1'b0, 3'b110, 32'h05, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 4'd0,  32'h0};
        tbl[12] = '{1'b1, 3'b000, 32'h3F, 32'h000000AB, 32'h0,        1'b0, 1'b0, 4'b1000, 4'd15, 32'hAB000000};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_flags", {30'h0, rsp_misaligned, rsp_illegal}, 32'd0);
        chk("rst_mem_strobes", {30'h0, mem_re, mem_we}, 32'd0);
        chk("rst_mem_be", {28'h0, mem_be}, 32'd0);
        chk("rst_mem_addr", {28'h0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // fill memory with aligned word stores
        for (int w = 0; w < MEM_WORDS; w++) run_req(1'b1, 3'b010, 32'(4 * w), $urandom);

        // directed vectors
        for (int i = 0; i < 13; i++) begin
            run_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd);
            chk($sformatf("tbl%0d_rdata", i), obs_rdata, tbl[i].rdata);
            chk($sformatf("tbl%0d_flags", i), {30'h0, obs_ill, obs_mis}, {30'h0, tbl[i].ill, tbl[i].mis});
            chk($sformatf("tbl%0d_be", i), {28'h0, obs_be1}, {28'h0, tbl[i].be});
            if (tbl[i].be != 4'h0) begin
                chk($sformatf("tbl%0d_maddr", i), {28'h0, obs_addr1}, {28'h0, tbl[i].maddr});
                if (tbl[i].we) chk($sformatf("tbl%0d_mwdata", i), obs_wd1, tbl[i].mwd);
            end
        end

`ifdef DMEM_LSU_MISALIGNED_EN
        // split store wrapping from the top word to word 0
        run_req(1'b1, 3'b010, 32'h3D, 32'hDEADBEEF);
        chk("split_acc1_addr", {28'h0, obs_addr1}, 32'd15);
        chk("split_acc1_be", {28'h0, obs_be1}, 32'b1110);
        chk("split_acc1_wd", obs_wd1, 32'hADBEEF00);
        chk("split_acc2_addr", {28'h0, obs_addr2}, 32'd0);
        chk("split_acc2_be", {28'h0, obs_be2}, 32'b0001);
        chk("split_acc2_wd", obs_wd2, 32'h000000DE);
        chk("split_lat", obs_lat, 32'd3);
        run_req(1'b0, 3'b010, 32'h3D, 32'h0);
        chk("split_load", obs_rdata, 32'hDEADBEEF);

        // reset during ACC2 of a split store: only the ACC1 bytes land
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h3E; req_wdata = 32'h11223344; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_acc1_be", {28'h0, mem_be}, 32'b1100);
        @(negedge clk);
        chk("rstmid_acc2_be", {28'h0, mem_be}, 32'b0011);
        rst_n = 1'b0;
        ref_mem[62] = 8'h44;
        ref_mem[63] = 8'h33;
`else
        // misaligned half-word refused
        run_req(1'b0, 3'b001, 32'h03, 32'h0);
        chk("mis_nstrobes", obs_nstr, 32'd0);
        chk("mis_flag", {31'h0, obs_mis}, 32'd1);
        chk("mis_rdata", obs_rdata, 32'h0);
        chk("mis_lat", obs_lat, 32'd2);

        // reset during ACC1 of a store: nothing lands
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_acc1_we", {31'h0, mem_we}, 32'd1);
        rst_n = 1'b0;
`endif
        #1;
        chk("rstmid_ready_now", {31'h0, req_ready}, 32'd1);
        chk("rstmid_strobes_now", {30'h0, mem_re, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        chk("rstmid_ready", {31'h0, req_ready}, 32'd1);
        chk("rstmid_no_rsp", {31'h0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rstmid_no_rsp_after", {31'h0, rsp_valid}, 32'd0);
        check_mem();

        // randomized traffic against the byte-level model
        for (int n = 0; n < 200; n++) begin
            run_req(1'($urandom), 3'($urandom_range(0, 7)),
                    {$urandom_range(0, 1) == 0 ? 26'h0 : 26'($urandom), 6'($urandom)}, $urandom);
        end
        check_mem();
        chk("never_both_strobes", both_strobes, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the execute stage and the byte-addressed data memory. Accepts one RV32 load/store per handshake, decodes funct3 into byte enables, lane-shifts store data, and sign/zero-extends load data. A misaligned access is split into two aligned word accesses. Illegal funct3 values are reported without touching memory.

## Interface
- `ADDR_W`, 6: data-memory byte-address width; memory holds 2^ADDR_W bytes.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle; a request is accepted when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr` in 32: byte address; only `[ADDR_W-1:0]` is used.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle response pulse; no backpressure.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_misaligned` out 1: misaligned access refused (only without the macro).
- `rsp_illegal` out 1: illegal funct3.
- `mem_addr` out ADDR_W-2: word index.
- `mem_re`, `mem_we` out 1: memory strobes; never both 1.
- `mem_be` out 4: byte-lane enables; bit n is byte n of the word.
- `mem_wdata` out 32: lane-shifted store data.
- `mem_rdata` in 32: combinational read of `mem_addr` in the same cycle.

## Operation
- **States:** IDLE, ACC1, ACC2, RESP.
- **Request latch:** `req_ready` = (state == IDLE). On accept, latch we, funct3, addr, wdata, then go to ACC1.
- **Decode:**
  - Size mask: B = 0001, H = 0011, W = 1111.
  - Offset: `off = addr[1:0]`.
  - Misaligned: H with off = 3, or W with off ≠ 0.
  - Illegal: funct3 ∈ {011, 110, 111}, or a store with funct3 100 or 101.
- **ACC1:**
  - `mem_addr` = addr[ADDR_W-1:2].
  - `mem_be` = (mask << off)[3:0].
  - `mem_wdata` = wdata << 8·off.
  - Capture `mem_rdata` into word0.
  - Next state: ACC2 if misaligned and `MISALIGNED_EN` is defined, else RESP.
- **ACC2:**
  - `mem_addr` = (word index + 1), wrapping modulo 2^(ADDR_W-2).
  - `mem_be` = mask >> (4−off).
  - `mem_wdata` = wdata >> 8·(4−off).
  - Capture `mem_rdata` into word1. Next state: RESP.
- **Load result:** ({word1, word0} >> 8·off), truncated to the access size, then sign-extended (B, H) or zero-extended (BU, HU, W). word1 is treated as 0 when unused.
- **Errors:** for illegal or refused-misaligned requests, ACC1 is still traversed but `mem_re`/`mem_we`/`mem_be` are held 0. Illegal takes priority over misaligned.
- **RESP:** `rsp_valid` = 1 with the flags, then IDLE.

## Timing
- **Latency (accept edge → `rsp_valid` cycle):**
  - Aligned or error: accept at edge 0, `rsp_valid` high in cycle 2.
  - Split: `rsp_valid` high in cycle 3.
- **Throughput:** one request per 3 (aligned) or 4 (split) cycles. `req_ready` is low from the accept edge until RESP exits.
- **Memory strobes:** combinational from state and latched request; writes commit at the rising edge ending ACC1/ACC2.
- **Reset values:** state IDLE, `req_ready` = 1. All other outputs 0: `rsp_*`, `mem_re`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`.
- **Reset mid-operation:** return to IDLE immediately. If reset lands after ACC1 of a split store, the ACC2 half is never issued (partial store permitted). No response is produced.
- **Wrap-around:** a split at the top word wraps to word 0.
- **Inputs while busy:** `req_*` is ignored while `req_ready` = 0.

## Configuration
- `DMEM_LSU_MISALIGNED_EN` defined: misaligned accesses are split into ACC1 + ACC2; `rsp_misaligned` is always 0.
- Not defined: ACC2 is unreachable. Misaligned requests get no memory strobes, and respond with `rsp_misaligned` = 1, `rsp_rdata` = 0.

## Structure
- **Package `dmem_lsu_pkg`:**
  - funct3 constants.
  - State enum.
  - Size-mask and illegal-decode functions.
- **Sub-module `dmem_lsu_align`:** combinational. Produces be/wdata shifting for both halves, plus load merge and extension. FSM and registers stay in `dmem_lsu`.

## Test plan
- LW at 0x08 after memory preload 0x8899AABB → ACC1 `mem_be` = 1111, `mem_addr` = 2; cycle 2 `rsp_rdata` = 0x8899AABB.
- LB at 0x0A, word = 0x0080FF00 → `rsp_rdata` = 0xFFFFFF80; LBU at same address → 0x00000080.
- SH 0x1234 at 0x06 → one write, `mem_be` = 1100, `mem_wdata` = 0x12340000; `rsp_valid` in cycle 2 with `rsp_rdata` = 0.
- With macro: SW 0xDEADBEEF at 0x3D (ADDR_W = 6) →
  - ACC1: word 15, `mem_be` = 1110, `mem_wdata` = 0xADBEEF00.
  - ACC2: word 0 (wrap), `mem_be` = 0001, `mem_wdata` = 0x000000DE.
  - `rsp_valid` in cycle 3.
- Without macro: LH at 0x03 → no `mem_re`; cycle 2 `rsp_misaligned` = 1, `rsp_rdata` = 0. funct3 = 011 load → `rsp_illegal` = 1, no strobes.
- Reset: `rst_n` low during ACC2 of a split store → next cycle state IDLE, `req_ready` = 1, no `rsp_valid`; only the ACC1 bytes are written.
